// File: rtl/ds_demux_pkg.sv
// Shared types and helpers for the DataStream demultiplexer.
// The optional DS_DEMUX_STAT_EN build uses CNT_WIDTH for its per-stream counters.
package ds_demux_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int CNT_WIDTH   = 32;
    localparam int MAX_OUTPUTS = 64;

    // Bit idx set when idx < n, all zero otherwise; callers size-cast to their lane count.
    function automatic logic [MAX_OUTPUTS-1:0] onehot(input int idx, input int n);
        logic [MAX_OUTPUTS-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_OUTPUTS; i++) begin
            if (i == idx && i < n) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/ds_demux_if.sv
// Stream bundle of the demultiplexer: one inbound stream with its select, OUTPUTS outbound lanes.
// A word moves on a stream exactly in the cycle where valid and ready are both high at the
// rising clk edge; valid never depends on ready, and a valid word with its data is held until taken.
interface ds_demux_if #(
    parameter int WIDTH   = 8,
    parameter int OUTPUTS = 2
);
    localparam int SEL_W = $clog2(OUTPUTS);

    logic [SEL_W-1:0]              select;
    logic [WIDTH-1:0]              i_dat;
    logic                          i_val;
    logic                          i_rdy;
    logic [OUTPUTS-1:0][WIDTH-1:0] o_dat;
    logic [OUTPUTS-1:0]            o_val;
    logic [OUTPUTS-1:0]            o_rdy;

    modport master (
        output select, i_dat, i_val, o_rdy,
        input  i_rdy, o_dat, o_val
    );

    modport slave (
        input  select, i_dat, i_val, o_rdy,
        output i_rdy, o_dat, o_val
    );

endinterface

// File: rtl/ds_skid_buffer.sv
// Generic two-entry stream skid stage: head register drives the output, skid register
// absorbs one extra word so the registered ready can lag by a cycle without losing data.
module ds_skid_buffer
    import ds_demux_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_val_i,
    output logic         in_rdy_o,
    input  logic [W-1:0] in_dat_i,
    output logic         out_val_o,
    input  logic         out_rdy_i,
    output logic [W-1:0] out_dat_o,
    output state_t       state_o
);

    state_t       state_q, state_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] skid_q, skid_d;
    logic         rdy_q;
    logic         inbound;
    logic         acc;

    assign inbound = in_val_i & rdy_q;
    assign acc     = (state_q != EMPTY) & out_rdy_i;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (inbound) begin
                    head_d  = in_dat_i;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (inbound && acc) begin
                    head_d = in_dat_i;
                end else if (inbound) begin
                    skid_d  = in_dat_i;
                    state_d = FULL;
                end else if (acc) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // Ready is low here, so only the drain of the head can happen.
                if (acc) begin
                    head_d  = skid_q;
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            rdy_q   <= (state_d != FULL);
        end
    end

    assign in_rdy_o  = rdy_q;
    assign out_val_o = (state_q != EMPTY);
    assign out_dat_o = head_q;
    assign state_o   = state_q;

endmodule

// File: rtl/ds_demux.sv
// DataStream demultiplexer: routes each inbound word to the lane named by the select captured with it.
// Build with DS_DEMUX_STAT_EN to add per-lane transfer counters (o_cnt) and their clear input (clr).
module ds_demux
    import ds_demux_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int OUTPUTS = 2
) (
    input  logic      clk,
    input  logic      reset,
    ds_demux_if.slave bus,
    output state_t    dbg_state_o
`ifdef DS_DEMUX_STAT_EN
    ,
    input  logic                                clr,
    output logic [OUTPUTS-1:0][CNT_WIDTH-1:0]   o_cnt
`endif
);

    localparam int              SEL_W   = $clog2(OUTPUTS);
    localparam int              PW      = WIDTH + SEL_W;
    localparam logic [SEL_W:0]  OUT_LIM = OUTPUTS[SEL_W:0];

    logic               sel_ok;
    logic               in_val;
    logic [PW-1:0]      in_pkt;
    logic [PW-1:0]      head_pkt;
    logic               head_val;
    logic               head_rdy;
    logic [WIDTH-1:0]   head_dat;
    logic [SEL_W-1:0]   head_sel;
    logic [OUTPUTS-1:0] sel_lane;

    // An out-of-range word still handshakes inbound but never reaches the skid stage.
    assign sel_ok = ({1'b0, bus.select} < OUT_LIM);
    assign in_val = bus.i_val & sel_ok;
    assign in_pkt = {bus.i_dat, bus.select};

    ds_skid_buffer #(
        .W (PW)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_val_i  (in_val),
        .in_rdy_o  (bus.i_rdy),
        .in_dat_i  (in_pkt),
        .out_val_o (head_val),
        .out_rdy_i (head_rdy),
        .out_dat_o (head_pkt),
        .state_o   (dbg_state_o)
    );

    assign {head_dat, head_sel} = head_pkt;
    assign sel_lane = OUTPUTS'(onehot(int'(head_sel), OUTPUTS));
    assign head_rdy = |(sel_lane & bus.o_rdy);
    assign bus.o_val = head_val ? sel_lane : '0;

    for (genvar k = 0; k < OUTPUTS; k++) begin : g_lane
        assign bus.o_dat[k] = head_dat;
    end

`ifdef DS_DEMUX_STAT_EN
    logic [OUTPUTS-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int k = 0; k < OUTPUTS; k++) begin
            if (clr) begin
                cnt_d[k] = '0;
            end else if (bus.o_val[k] && bus.o_rdy[k]) begin
                cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_ds_demux.sv
// Directed bench for ds_demux: three instances (2, 3 and 4 lanes) sharing clock and reset.
// Outputs are sampled 1 time unit after the rising edge, inputs are changed right after sampling.
module tb_ds_demux;
    import ds_demux_pkg::*;

    logic clk;
    logic reset;
    logic clr;
    int   n_checks = 0;
    int   n_errors = 0;

    state_t st2, st3, st4;

    ds_demux_if #(.WIDTH(8), .OUTPUTS(2)) bus2 ();
    ds_demux_if #(.WIDTH(8), .OUTPUTS(3)) bus3 ();
    ds_demux_if #(.WIDTH(8), .OUTPUTS(4)) bus4 ();

`ifdef DS_DEMUX_STAT_EN
    logic [1:0][31:0] cnt2;
    logic [2:0][31:0] cnt3;
    logic [3:0][31:0] cnt4;
`endif

    ds_demux #(.WIDTH(8), .OUTPUTS(2)) u_d2 (
        .clk(clk), .reset(reset), .bus(bus2), .dbg_state_o(st2)
`ifdef DS_DEMUX_STAT_EN
        , .clr(clr), .o_cnt(cnt2)
`endif
    );

    ds_demux #(.WIDTH(8), .OUTPUTS(3)) u_d3 (
        .clk(clk), .reset(reset), .bus(bus3), .dbg_state_o(st3)
`ifdef DS_DEMUX_STAT_EN
        , .clr(clr), .o_cnt(cnt3)
`endif
    );

    ds_demux #(.WIDTH(8), .OUTPUTS(4)) u_d4 (
        .clk(clk), .reset(reset), .bus(bus4), .dbg_state_o(st4)
`ifdef DS_DEMUX_STAT_EN
        , .clr(clr), .o_cnt(cnt4)
`endif
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    initial begin
        logic [7:0] dat;
        logic [1:0] exp_val;

        reset = 1'b1;
        clr   = 1'b0;
        bus2.o_rdy = 2'b11; bus2.i_val = 1'b1; bus2.select = 1'b0; bus2.i_dat = 8'hA0;
        bus3.o_rdy = 3'b111; bus3.i_val = 1'b0; bus3.select = 2'd0; bus3.i_dat = 8'h00;
        bus4.o_rdy = 4'b0000; bus4.i_val = 1'b0; bus4.select = 2'd0; bus4.i_dat = 8'h00;
        tick();
        tick();

        // Reset state
        check("rst_irdy",  32'(bus2.i_rdy), 32'h0);
        check("rst_oval",  32'(bus2.o_val), 32'h0);
        check("rst_odat",  32'(bus2.o_dat[1]), 32'h0);
        check("rst_state", 32'(st2), 32'(EMPTY));

        // Release: ready only after the first edge, then streaming with no bubbles
        reset = 1'b0;
        #1;
        check("t1_irdy_pre", 32'(bus2.i_rdy), 32'h0);
        tick();
        check("t1_irdy_up", 32'(bus2.i_rdy), 32'h1);
        check("t1_oval_up", 32'(bus2.o_val), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            dat = 8'hA0 + 8'(i);
            exp_val = (i % 2 == 0) ? 2'b01 : 2'b10;
            check("t1_oval",  32'(bus2.o_val), 32'(exp_val));
            check("t1_odat0", 32'(bus2.o_dat[0]), 32'(dat));
            check("t1_odat1", 32'(bus2.o_dat[1]), 32'(dat));
            check("t1_irdy",  32'(bus2.i_rdy), 32'h1);
            if (i < 3) begin
                bus2.i_dat  = dat + 8'd1;
                bus2.select = ~bus2.select;
            end else begin
                bus2.i_val = 1'b0;
            end
        end
        tick();
        check("t1_oval_end", 32'(bus2.o_val), 32'h0);
        check("t1_state_end", 32'(st2), 32'(EMPTY));

        // Four lanes: stall lane 2 until FULL, then drain 0x11, 0x22 back to back
        bus4.select = 2'd2; bus4.i_dat = 8'h11; bus4.i_val = 1'b1;
        tick();
        check("t2_oval_a", 32'(bus4.o_val), 32'h4);
        check("t2_odat_a", 32'(bus4.o_dat[2]), 32'h11);
        check("t2_irdy_a", 32'(bus4.i_rdy), 32'h1);
        bus4.i_dat = 8'h22;
        tick();
        check("t2_state_b", 32'(st4), 32'(FULL));
        check("t2_irdy_b",  32'(bus4.i_rdy), 32'h0);
        check("t2_oval_b",  32'(bus4.o_val), 32'h4);
        check("t2_odat_b",  32'(bus4.o_dat[2]), 32'h11);
        bus4.i_val = 1'b0;
        tick();
        check("t2_state_c", 32'(st4), 32'(FULL));
        check("t2_oval_c",  32'(bus4.o_val), 32'h4);
        check("t2_odat_c",  32'(bus4.o_dat[2]), 32'h11);
        bus4.o_rdy = 4'b1011;
        tick();
        check("t2_oval_d", 32'(bus4.o_val), 32'h4);
        check("t2_odat_d", 32'(bus4.o_dat[2]), 32'h11);
        check("t2_irdy_d", 32'(bus4.i_rdy), 32'h0);
        bus4.o_rdy = 4'b0100;
        tick();
        check("t2_oval_e",  32'(bus4.o_val), 32'h4);
        check("t2_odat_e",  32'(bus4.o_dat[2]), 32'h22);
        check("t2_irdy_e",  32'(bus4.i_rdy), 32'h1);
        check("t2_state_e", 32'(st4), 32'(BUSY));
        tick();
        check("t2_oval_f",  32'(bus4.o_val), 32'h0);
        check("t2_state_f", 32'(st4), 32'(EMPTY));
        bus4.o_rdy = 4'b0000;

        // Select changes while a lane-1 word is stalled: no re-routing, order kept
        bus2.o_rdy = 2'b00; bus2.select = 1'b1; bus2.i_dat = 8'hB1; bus2.i_val = 1'b1;
        tick();
        check("t3_oval_a", 32'(bus2.o_val), 32'h2);
        bus2.select = 1'b0; bus2.i_dat = 8'hB0;
        tick();
        check("t3_oval_b", 32'(bus2.o_val), 32'h2);
        check("t3_odat_b", 32'(bus2.o_dat[1]), 32'hB1);
        check("t3_irdy_b", 32'(bus2.i_rdy), 32'h0);
        bus2.i_val = 1'b0; bus2.o_rdy = 2'b01;
        tick();
        check("t3_oval_c", 32'(bus2.o_val), 32'h2);
        check("t3_odat_c", 32'(bus2.o_dat[1]), 32'hB1);
        bus2.o_rdy = 2'b10;
        tick();
        check("t3_oval_d", 32'(bus2.o_val), 32'h1);
        check("t3_odat_d", 32'(bus2.o_dat[0]), 32'hB0);
        bus2.o_rdy = 2'b01;
        tick();
        check("t3_oval_e", 32'(bus2.o_val), 32'h0);
        bus2.o_rdy = 2'b11;

        // Three lanes: select 3 is out of range and silently dropped
        bus3.select = 2'd3; bus3.i_dat = 8'h55; bus3.i_val = 1'b1;
        check("t4_irdy_pre", 32'(bus3.i_rdy), 32'h1);
        tick();
        check("t4_oval_drop",  32'(bus3.o_val), 32'h0);
        check("t4_state_drop", 32'(st3), 32'(EMPTY));
        check("t4_irdy_drop",  32'(bus3.i_rdy), 32'h1);
        bus3.select = 2'd1; bus3.i_dat = 8'h66;
        tick();
        check("t4_oval_66", 32'(bus3.o_val), 32'h2);
        check("t4_odat_66", 32'(bus3.o_dat[1]), 32'h66);
        bus3.i_val = 1'b0;
        tick();
        check("t4_oval_end", 32'(bus3.o_val), 32'h0);
        bus3.o_rdy = 3'b000; bus3.select = 2'd0; bus3.i_dat = 8'h77; bus3.i_val = 1'b1;
        tick();
        bus3.select = 2'd3; bus3.i_dat = 8'h99;
        tick();
        check("t4_state_busy", 32'(st3), 32'(BUSY));
        check("t4_irdy_busy",  32'(bus3.i_rdy), 32'h1);
        check("t4_odat_busy",  32'(bus3.o_dat[0]), 32'h77);
        check("t4_oval_busy",  32'(bus3.o_val), 32'h1);
        bus3.i_val = 1'b0; bus3.o_rdy = 3'b001;
        tick();
        check("t4_state_end", 32'(st3), 32'(EMPTY));

        // Asynchronous reset while FULL
        bus4.o_rdy = 4'b0000; bus4.select = 2'd1; bus4.i_dat = 8'h77; bus4.i_val = 1'b1;
        tick();
        bus4.i_dat = 8'h88;
        tick();
        check("t5_state_full", 32'(st4), 32'(FULL));
        bus4.i_val = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("t5_oval_rst",  32'(bus4.o_val), 32'h0);
        check("t5_irdy_rst",  32'(bus4.i_rdy), 32'h0);
        check("t5_odat_rst",  32'(bus4.o_dat[1]), 32'h0);
        check("t5_state_rst", 32'(st4), 32'(EMPTY));
        #2;
        reset = 1'b0;
        #1;
        check("t5_irdy_rel", 32'(bus4.i_rdy), 32'h0);
        tick();
        check("t5_irdy_up",  32'(bus4.i_rdy), 32'h1);
        check("t5_state_up", 32'(st4), 32'(EMPTY));
        check("t5_oval_up",  32'(bus4.o_val), 32'h0);

`ifdef DS_DEMUX_STAT_EN
        // Per-lane transfer counters: clear, count, clear, wrap
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t6_cnt0_clr", cnt2[0], 32'h0);
        check("t6_cnt1_clr", cnt2[1], 32'h0);
        bus2.o_rdy = 2'b11; bus2.i_val = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus2.select = (i < 5) ? 1'b0 : 1'b1;
            bus2.i_dat  = 8'(i);
            tick();
        end
        bus2.i_val = 1'b0;
        tick();
        tick();
        check("t6_cnt0", cnt2[0], 32'd5);
        check("t6_cnt1", cnt2[1], 32'd2);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t6_cnt0_clr2", cnt2[0], 32'h0);
        check("t6_cnt1_clr2", cnt2[1], 32'h0);
        force u_d2.cnt_q = {32'd0, 32'hFFFF_FFFE};
        #1;
        release u_d2.cnt_q;
        bus2.select = 1'b0; bus2.i_val = 1'b1;
        tick();
        tick();
        bus2.i_val = 1'b0;
        check("t6_cnt0_max", cnt2[0], 32'hFFFF_FFFF);
        tick();
        check("t6_cnt0_wrap", cnt2[0], 32'h0);
        check("t6_cnt1_wrap", cnt2[1], 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
